// File: rtl/spi_rx_deser.sv
// spi_rx_deser: oversampling SPI receiver that rebuilds LSB-first WIDTH-bit words
// from sclk/cs/mosi and presents them on a one-entry valid/ready output register.
module spi_rx_deser #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SKIP_EDGES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CH    = SYNC_STAGES + 1;
  localparam int unsigned BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned EW    = (SKIP_EDGES > 0) ? $clog2(SKIP_EDGES + 1) : 1;
  localparam int unsigned FLUSH = SYNC_STAGES + 1;
  localparam int unsigned FW    = $clog2(FLUSH + 1);

  typedef enum logic [1:0] {S_WAIT_CS, S_IDLE, S_SETUP, S_SHIFT} state_t;

  state_t state_q, state_d;

  // Synchroniser chains; the last element is the edge detector's delayed copy.
  logic [CH-1:0]    sclk_ch_q, sclk_ch_d;
  logic [CH-1:0]    cs_ch_q, cs_ch_d;
  logic [CH-1:0]    mosi_ch_q, mosi_ch_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             done_q, done_d;
  logic             post_word_q, post_word_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;

  logic rise, cs_dly, mosi_dly, flushed;

  assign rise     = sclk_ch_q[CH-2] & ~sclk_ch_q[CH-1];
  assign cs_dly   = cs_ch_q[CH-1];
  assign mosi_dly = mosi_ch_q[CH-1];
  // Chains reload idle values on reset, so cs is only trusted once they have refilled.
  assign flushed  = (flush_cnt_q == FW'(FLUSH));

  always_comb begin
    sclk_ch_d   = {sclk_ch_q[CH-2:0], sclk};
    cs_ch_d     = {cs_ch_q[CH-2:0], cs};
    mosi_ch_d   = {mosi_ch_q[CH-2:0], mosi};
    flush_cnt_d = flushed ? flush_cnt_q : flush_cnt_q + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_WAIT_CS;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_CS: if (flushed && cs_dly) state_d = S_IDLE;
      S_IDLE:    if (!cs_dly) state_d = S_SETUP;
      S_SETUP: begin
        if (cs_dly)                               state_d = S_IDLE;
        else if (edge_cnt_q == EW'(SKIP_EDGES))   state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cs_dly)                                       state_d = S_IDLE;
        else if (rise && bit_cnt_q == BW'(WIDTH - 1))     state_d = S_WAIT_CS;
      end
      default: state_d = S_WAIT_CS;
    endcase
  end

  always_comb begin
    edge_cnt_d  = edge_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
    post_word_d = post_word_q;
    frame_err_d = 1'b0;
    case (state_q)
      S_WAIT_CS: begin
        // Only a frame that already delivered a word reports trailing clocks, once.
        if (cs_dly) begin
          post_word_d = 1'b0;
        end else if (post_word_q && rise) begin
          frame_err_d = 1'b1;
          post_word_d = 1'b0;
        end
      end
      S_IDLE: begin
        edge_cnt_d  = '0;
        post_word_d = 1'b0;
      end
      S_SETUP: begin
        bit_cnt_d = '0;
        if (cs_dly)                                          frame_err_d = 1'b1;
        else if (rise && edge_cnt_q != EW'(SKIP_EDGES))      edge_cnt_d  = edge_cnt_q + EW'(1);
      end
      S_SHIFT: begin
        if (cs_dly) begin
          frame_err_d = 1'b1;
        end else if (rise) begin
          shreg_d[bit_cnt_q] = mosi_dly;
          bit_cnt_d          = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(WIDTH - 1)) begin
            done_d      = 1'b1;
            post_word_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d == S_SETUP) || (state_d == S_SHIFT);
  end

  // One-entry output register: a handshake in the completion cycle frees the slot.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overflow_d   = 1'b0;
    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
    if (done_q) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shreg_q;
        dout_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_ch_q    <= '0;
      cs_ch_q      <= '1;
      mosi_ch_q    <= '0;
      flush_cnt_q  <= '0;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      done_q       <= 1'b0;
      post_word_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sclk_ch_q    <= sclk_ch_d;
      cs_ch_q      <= cs_ch_d;
      mosi_ch_q    <= mosi_ch_d;
      flush_cnt_q  <= flush_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      done_q       <= done_d;
      post_word_q  <= post_word_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_rx_deser.sv
// tb_spi_rx_deser: drives master-style SPI frames into spi_rx_deser and checks
// delivered words, error/overflow pulses and latency against a frame-level model.
`timescale 1ns/1ps
module tb_spi_rx_deser;
  localparam int unsigned WIDTH       = 12;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned SKIP_EDGES  = 1;
  localparam int          LAT         = SYNC_STAGES + 2;

  logic             clk = 1'b0;
  logic             rst, sclk, cs, mosi, dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, frame_err, overflow, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rise_cyc = -1;

  // Monitor state (written only by the monitor).
  logic [WIDTH-1:0] got_q[$];
  int err_cnt = 0, ovf_cnt = 0, valid_cyc = 0, gap_cyc = 0, busy_cyc = 0;
  int valid_rise_cyc = -1;
  logic prev_valid = 1'b0;

  spi_rx_deser #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .SKIP_EDGES(SKIP_EDGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_valid && dout_ready) got_q.push_back(dout);
    if (frame_err) err_cnt++;
    if (overflow) ovf_cnt++;
    if (dout_valid) valid_cyc++;
    else gap_cyc++;
    if (busy) busy_cyc++;
    if (dout_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = dout_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles want fewer", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master-style frame: cs falls on rise 0, bits on rises 1..ndata, cs rises on rise ndata+1.
  task automatic send_frame(input logic [15:0] bits, input int ndata, input int hp, input int rst_rise);
    for (int r = 0; r <= ndata + 1; r++) begin
      sclk = 1'b1;
      if (r == 0) cs = 1'b0;
      else if (r <= ndata) mosi = bits[r-1];
      else cs = 1'b1;
      if (r == int'(SKIP_EDGES + WIDTH)) last_rise_cyc = cyc;
      tick(hp);
      sclk = 1'b0;
      if (r == rst_rise) begin
        rst = 1'b1; tick(1); rst = 1'b0; tick(hp - 1);
      end else begin
        tick(hp);
      end
    end
    tick(hp);
  endtask

  task automatic test_reset;
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; dout_ready = 1'b0;
    tick(3);
    n_vec++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout: got %h want %h", dout, 12'h000); end
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick(10);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_nominal;
    int g0, e0, v0, b0, lat;
    logic [WIDTH-1:0] w;
    dout_ready = 1'b1;
    g0 = got_q.size(); e0 = err_cnt; v0 = valid_cyc; b0 = busy_cyc;
    send_frame(16'h0A5C, 12, 51, -1);
    w = (got_q.size() > g0) ? got_q[g0] : 'x;
    n_vec++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL nominal_count: got %0d want 1", got_q.size() - g0); end
    n_vec++; if (w !== 12'hA5C) begin n_err++; $display("FAIL nominal_word: got %h want a5c", w); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL nominal_frame_err: got %0d want 0", err_cnt - e0); end
    n_vec++; if (valid_cyc - v0 !== 1) begin n_err++; $display("FAIL nominal_valid_cycles: got %0d want 1", valid_cyc - v0); end
    n_vec++; if (busy_cyc - b0 == 0) begin n_err++; $display("FAIL nominal_busy_seen: got 0 cycles want >0"); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL nominal_busy_after: got %b want 0", busy); end
    lat = valid_rise_cyc - last_rise_cyc;
    n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL nominal_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back;
    int g0, e0, o0;
    logic [WIDTH-1:0] w;
    dout_ready = 1'b0;
    g0 = got_q.size(); e0 = err_cnt; o0 = ovf_cnt;
    send_frame(16'h0001, 12, 20, -1);
    send_frame(16'h0800, 12, 20, -1);
    n_vec++; if (dout !== 12'h001) begin n_err++; $display("FAIL b2b_held_dout: got %h want 001", dout); end
    n_vec++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL b2b_held_valid: got %b want 1", dout_valid); end
    n_vec++; if (ovf_cnt - o0 !== 1) begin n_err++; $display("FAIL b2b_overflow: got %0d want 1", ovf_cnt - o0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL b2b_frame_err: got %0d want 0", err_cnt - e0); end
    dout_ready = 1'b1; tick(1); dout_ready = 1'b0;
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_clear: got %b want 0", dout_valid); end
    w = (got_q.size() > g0) ? got_q[g0] : 'x;
    n_vec++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL b2b_accepted: got %0d want 1", got_q.size() - g0); end
    n_vec++; if (w !== 12'h001) begin n_err++; $display("FAIL b2b_word: got %h want 001", w); end
    tick(2);
  endtask

  task automatic test_short;
    int g0, e0;
    logic [WIDTH-1:0] w;
    dout_ready = 1'b1;
    g0 = got_q.size(); e0 = err_cnt;
    send_frame(16'($urandom), 5, 20, -1);
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL short_frame_err: got %0d want 1", err_cnt - e0); end
    n_vec++; if (got_q.size() - g0 !== 0) begin n_err++; $display("FAIL short_no_word: got %0d want 0", got_q.size() - g0); end
    e0 = err_cnt;
    send_frame(16'h03C3, 12, 20, -1);
    w = (got_q.size() > g0) ? got_q[g0] : 'x;
    n_vec++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL short_next_count: got %0d want 1", got_q.size() - g0); end
    n_vec++; if (w !== 12'h3C3) begin n_err++; $display("FAIL short_next_word: got %h want 3c3", w); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL short_next_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_long;
    int g0, e0;
    logic [WIDTH-1:0] w;
    logic [15:0] bits;
    dout_ready = 1'b1;
    g0 = got_q.size(); e0 = err_cnt;
    bits = {2'b00, 2'($urandom), 12'hFFF};
    send_frame(bits, 14, 20, -1);
    w = (got_q.size() > g0) ? got_q[g0] : 'x;
    n_vec++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL long_count: got %0d want 1", got_q.size() - g0); end
    n_vec++; if (w !== 12'hFFF) begin n_err++; $display("FAIL long_word: got %h want fff", w); end
    n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL long_frame_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    int g0, e0, o0;
    logic [WIDTH-1:0] w;
    dout_ready = 1'b1;
    g0 = got_q.size(); e0 = err_cnt; o0 = ovf_cnt;
    send_frame(16'($urandom), 12, 20, 7);
    n_vec++; if (got_q.size() - g0 !== 0) begin n_err++; $display("FAIL rstmid_no_word: got %0d want 0", got_q.size() - g0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL rstmid_frame_err: got %0d want 0", err_cnt - e0); end
    n_vec++; if (ovf_cnt - o0 !== 0) begin n_err++; $display("FAIL rstmid_overflow: got %0d want 0", ovf_cnt - o0); end
    n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", dout_valid); end
    send_frame(16'h05A5, 12, 20, -1);
    w = (got_q.size() > g0) ? got_q[g0] : 'x;
    n_vec++; if (w !== 12'h5A5) begin n_err++; $display("FAIL rstmid_next_word: got %h want 5a5", w); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL rstmid_next_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_simultaneous;
    int g0, o0, gp0;
    logic [WIDTH-1:0] w0, w1;
    dout_ready = 1'b0;
    g0 = got_q.size();
    send_frame(16'h0456, 12, 20, -1);
    o0 = ovf_cnt; gp0 = gap_cyc;
    last_rise_cyc = -1;
    fork
      send_frame(16'h0123, 12, 20, -1);
      begin
        for (int i = 0; i < 5000 && last_rise_cyc < 0; i++) tick(1);
        n_vec++; if (last_rise_cyc < 0) begin n_err++; $display("FAIL simul_sync: got no final rise want one"); end
        while (cyc < last_rise_cyc + LAT - 1) tick(1);
        dout_ready = 1'b1; tick(1); dout_ready = 1'b0;
      end
    join
    w0 = (got_q.size() > g0) ? got_q[g0] : 'x;
    n_vec++; if (got_q.size() - g0 !== 1) begin n_err++; $display("FAIL simul_count: got %0d want 1", got_q.size() - g0); end
    n_vec++; if (w0 !== 12'h456) begin n_err++; $display("FAIL simul_old_word: got %h want 456", w0); end
    n_vec++; if (dout !== 12'h123) begin n_err++; $display("FAIL simul_new_dout: got %h want 123", dout); end
    n_vec++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL simul_valid: got %b want 1", dout_valid); end
    n_vec++; if (gap_cyc - gp0 !== 0) begin n_err++; $display("FAIL simul_valid_gap: got %0d want 0", gap_cyc - gp0); end
    n_vec++; if (ovf_cnt - o0 !== 0) begin n_err++; $display("FAIL simul_overflow: got %0d want 0", ovf_cnt - o0); end
    dout_ready = 1'b1; tick(2);
    w1 = (got_q.size() > g0 + 1) ? got_q[g0+1] : 'x;
    n_vec++; if (w1 !== 12'h123) begin n_err++; $display("FAIL simul_drain: got %h want 123", w1); end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] held_w, w;
    logic [15:0] bits;
    bit held, rdy;
    int g0, e0, o0, nd, hp, exp_fe, exp_ovf;
    held = 1'b0; held_w = '0;
    dout_ready = 1'b1; tick(2);
    g0 = got_q.size();
    for (int f = 0; f < 10; f++) begin
      rdy  = ($urandom_range(0, 3) != 0);
      nd   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 15)) : 12;
      bits = 16'($urandom);
      hp   = int'($urandom_range(8, 24));
      dout_ready = rdy;
      if (rdy && held) begin exp_q.push_back(held_w); held = 1'b0; end
      e0 = err_cnt; o0 = ovf_cnt;
      send_frame(bits, nd, hp, -1);
      exp_fe  = (nd != int'(WIDTH)) ? 1 : 0;
      exp_ovf = 0;
      if (nd >= int'(WIDTH)) begin
        if (rdy) exp_q.push_back(bits[WIDTH-1:0]);
        else if (held) exp_ovf = 1;
        else begin held = 1'b1; held_w = bits[WIDTH-1:0]; end
      end
      n_vec++; if (err_cnt - e0 !== exp_fe) begin n_err++; $display("FAIL rand%0d_frame_err: got %0d want %0d (nd=%0d)", f, err_cnt - e0, exp_fe, nd); end
      n_vec++; if (ovf_cnt - o0 !== exp_ovf) begin n_err++; $display("FAIL rand%0d_overflow: got %0d want %0d", f, ovf_cnt - o0, exp_ovf); end
    end
    dout_ready = 1'b1; tick(3);
    if (held) exp_q.push_back(held_w);
    n_vec++; if (got_q.size() - g0 !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - g0, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      w = (got_q.size() > g0 + i) ? got_q[g0+i] : 'x;
      n_vec++; if (w !== exp_q[i]) begin n_err++; $display("FAIL rand_word%0d: got %h want %h", i, w, exp_q[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_back_to_back;
    test_short;
    test_long;
    test_reset_mid;
    test_simultaneous;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
